// File: rtl/uart_alu_top_pkg.sv
// ---------------------------------------------------------------------------
// uart_alu_top_pkg
// Shared definitions for the serial-controlled ALU: opcode encodings,
// UART RX/TX state encodings and the operand-sequencing FSM encodings.
// ---------------------------------------------------------------------------
package uart_alu_top_pkg;

   localparam int unsigned OP_W = 6;

   // ALU opcodes (6-bit function field)
   localparam logic [OP_W-1:0] OP_ADD = 6'b100000;
   localparam logic [OP_W-1:0] OP_SUB = 6'b100010;
   localparam logic [OP_W-1:0] OP_AND = 6'b100100;
   localparam logic [OP_W-1:0] OP_OR  = 6'b100101;
   localparam logic [OP_W-1:0] OP_XOR = 6'b100110;
   localparam logic [OP_W-1:0] OP_NOR = 6'b100111;
   localparam logic [OP_W-1:0] OP_SRA = 6'b000011;
   localparam logic [OP_W-1:0] OP_SRL = 6'b000010;

   // Shared by the receiver and the transmitter
   typedef enum logic [1:0] {
      UART_IDLE  = 2'd0,
      UART_START = 2'd1,
      UART_DATA  = 2'd2,
      UART_STOP  = 2'd3
   } uart_state_e;

   // Operand/opcode collection sequence
   typedef enum logic [1:0] {
      IF_WAIT_A  = 2'd0,
      IF_WAIT_B  = 2'd1,
      IF_WAIT_OP = 2'd2,
      IF_SEND    = 2'd3
   } if_state_e;

endpackage : uart_alu_top_pkg

// File: rtl/uart_alu_top_alu_unit.sv
// ---------------------------------------------------------------------------
// alu_unit
// Purely combinational N_BITS-wide ALU. Carry/borrow are discarded and
// unknown opcodes yield zero.
//   i_a, i_b  : operands
//   i_op      : 6-bit opcode
//   o_result  : N_BITS-wide result
// ---------------------------------------------------------------------------
module alu_unit #(
   parameter int unsigned N_BITS = 8
) (
   input  logic [N_BITS-1:0]                   i_a,
   input  logic [N_BITS-1:0]                   i_b,
   input  logic [uart_alu_top_pkg::OP_W-1:0]   i_op,
   output logic [N_BITS-1:0]                   o_result
);
   import uart_alu_top_pkg::*;

   // Shifts by N_BITS or more saturate to sign fill (SRA) or zero (SRL)
   always_comb begin
      o_result = '0;
      case (i_op)
         OP_ADD:  o_result = i_a + i_b;
         OP_SUB:  o_result = i_a - i_b;
         OP_AND:  o_result = i_a & i_b;
         OP_OR:   o_result = i_a | i_b;
         OP_XOR:  o_result = i_a ^ i_b;
         OP_NOR:  o_result = ~(i_a | i_b);
         OP_SRA:  o_result = N_BITS'($signed(i_a) >>> i_b);
         OP_SRL:  o_result = i_a >> i_b;
         default: o_result = '0;
      endcase
   end

endmodule : alu_unit

// File: rtl/uart_alu_top.sv
// ---------------------------------------------------------------------------
// uart_alu_top
// Serial-controlled ALU. A UART receiver collects operand A, operand B and
// the opcode (three 8N1 frames), the ALU result is sent back as one frame.
// Oversampling baud generator, RX, sequencing FSM and TX live here.
//
// Ports:
//   i_clock        : system clock (single domain)
//   i_reset        : synchronous active-high reset
//   i_rx           : UART serial input, idles high
//   o_tx_done_tick : one-clock pulse when the TX stop bit completes
//   o_tx           : UART serial output, idles high
//
// Build option:
//   UART_FRAME_CHECK_EN - when defined, a frame whose stop bit samples low
//   is dropped (no rx_done, sequencer does not advance).
// ---------------------------------------------------------------------------
module uart_alu_top
   import uart_alu_top_pkg::*;
#(
   parameter int unsigned LIMITE   = 163,
   parameter int unsigned NB_CONTA = 8,
   parameter int unsigned N_BITS   = 8,
   parameter int unsigned N_TICKS  = 16
) (
   input  logic i_clock,
   input  logic i_reset,
   input  logic i_rx,
   output logic o_tx_done_tick,
   output logic o_tx
);

   localparam int unsigned TICK_W = $clog2(N_TICKS);
   localparam int unsigned BIT_W  = (N_BITS > 1) ? $clog2(N_BITS) : 1;

   // ---------------- baud tick generator ----------------
   logic [NB_CONTA-1:0] r_baud_cnt;
   logic                w_tick;

   assign w_tick = (r_baud_cnt == NB_CONTA'(LIMITE - 1));

   always_ff @(posedge i_clock) begin
      if (i_reset)     r_baud_cnt <= '0;
      else if (w_tick) r_baud_cnt <= '0;
      else             r_baud_cnt <= r_baud_cnt + NB_CONTA'(1);
   end

   // ---------------- input synchronizer ----------------
   logic [1:0] r_rx_sync;
   logic       w_rx;

   always_ff @(posedge i_clock) begin
      if (i_reset) r_rx_sync <= 2'b11;
      else         r_rx_sync <= {r_rx_sync[0], i_rx};
   end

   assign w_rx = r_rx_sync[1];

   // ---------------- receiver ----------------
   uart_state_e          r_rx_state,  w_rx_state_nxt;
   logic [TICK_W-1:0]    r_rx_tick,   w_rx_tick_nxt;
   logic [BIT_W-1:0]     r_rx_bit,    w_rx_bit_nxt;
   logic [N_BITS-1:0]    r_rx_data,   w_rx_data_nxt;
   logic                 r_rx_done,   w_rx_done_nxt;

   // START waits half a bit to land mid-bit; later states step a full bit
   always_comb begin
      w_rx_state_nxt = r_rx_state;
      w_rx_tick_nxt  = r_rx_tick;
      w_rx_bit_nxt   = r_rx_bit;
      w_rx_data_nxt  = r_rx_data;
      w_rx_done_nxt  = 1'b0;
      case (r_rx_state)
         UART_IDLE: begin
            if (!w_rx) begin
               w_rx_state_nxt = UART_START;
               w_rx_tick_nxt  = '0;
            end
         end
         UART_START: begin
            if (w_tick) begin
               if (r_rx_tick == TICK_W'(N_TICKS / 2 - 1)) begin
                  w_rx_tick_nxt = '0;
                  if (!w_rx) begin
                     w_rx_state_nxt = UART_DATA;
                     w_rx_bit_nxt   = '0;
                  end else begin
                     // line went back high: glitch, not a start bit
                     w_rx_state_nxt = UART_IDLE;
                  end
               end else begin
                  w_rx_tick_nxt = r_rx_tick + TICK_W'(1);
               end
            end
         end
         UART_DATA: begin
            if (w_tick) begin
               if (r_rx_tick == TICK_W'(N_TICKS - 1)) begin
                  w_rx_tick_nxt = '0;
                  w_rx_data_nxt = {w_rx, r_rx_data[N_BITS-1:1]};
                  if (r_rx_bit == BIT_W'(N_BITS - 1)) w_rx_state_nxt = UART_STOP;
                  else                                w_rx_bit_nxt   = r_rx_bit + BIT_W'(1);
               end else begin
                  w_rx_tick_nxt = r_rx_tick + TICK_W'(1);
               end
            end
         end
         UART_STOP: begin
            if (w_tick) begin
               if (r_rx_tick == TICK_W'(N_TICKS - 1)) begin
                  // here the line is at the middle of the stop bit
                  w_rx_state_nxt = UART_IDLE;
                  w_rx_tick_nxt  = '0;
`ifdef UART_FRAME_CHECK_EN
                  w_rx_done_nxt  = w_rx;
`else
                  w_rx_done_nxt  = 1'b1;
`endif
               end else begin
                  w_rx_tick_nxt = r_rx_tick + TICK_W'(1);
               end
            end
         end
         default: w_rx_state_nxt = UART_IDLE;
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_rx_state <= UART_IDLE;
         r_rx_tick  <= '0;
         r_rx_bit   <= '0;
         r_rx_data  <= '0;
         r_rx_done  <= 1'b0;
      end else begin
         r_rx_state <= w_rx_state_nxt;
         r_rx_tick  <= w_rx_tick_nxt;
         r_rx_bit   <= w_rx_bit_nxt;
         r_rx_data  <= w_rx_data_nxt;
         r_rx_done  <= w_rx_done_nxt;
      end
   end

   // ---------------- operand sequencer ----------------
   if_state_e            r_if_state, w_if_state_nxt;
   logic [N_BITS-1:0]    r_a,        w_a_nxt;
   logic [N_BITS-1:0]    r_b,        w_b_nxt;
   logic [OP_W-1:0]      r_op,       w_op_nxt;
   logic                 w_tx_start;
   logic [N_BITS-1:0]    w_alu_result;

   // SEND never waits on TX: the next request is at least three frames away
   always_comb begin
      w_if_state_nxt = r_if_state;
      w_a_nxt        = r_a;
      w_b_nxt        = r_b;
      w_op_nxt       = r_op;
      w_tx_start     = 1'b0;
      case (r_if_state)
         IF_WAIT_A: begin
            if (r_rx_done) begin
               w_a_nxt        = r_rx_data;
               w_if_state_nxt = IF_WAIT_B;
            end
         end
         IF_WAIT_B: begin
            if (r_rx_done) begin
               w_b_nxt        = r_rx_data;
               w_if_state_nxt = IF_WAIT_OP;
            end
         end
         IF_WAIT_OP: begin
            if (r_rx_done) begin
               w_op_nxt       = r_rx_data[OP_W-1:0];
               w_if_state_nxt = IF_SEND;
            end
         end
         IF_SEND: begin
            w_tx_start     = 1'b1;
            w_if_state_nxt = IF_WAIT_A;
         end
         default: w_if_state_nxt = IF_WAIT_A;
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_if_state <= IF_WAIT_A;
         r_a        <= '0;
         r_b        <= '0;
         r_op       <= '0;
      end else begin
         r_if_state <= w_if_state_nxt;
         r_a        <= w_a_nxt;
         r_b        <= w_b_nxt;
         r_op       <= w_op_nxt;
      end
   end

   // ---------------- ALU ----------------
   alu_unit #(
      .N_BITS (N_BITS)
   ) u_alu (
      .i_a      (r_a),
      .i_b      (r_b),
      .i_op     (r_op),
      .o_result (w_alu_result)
   );

   // ---------------- transmitter ----------------
   uart_state_e          r_tx_state, w_tx_state_nxt;
   logic [TICK_W-1:0]    r_tx_tick,  w_tx_tick_nxt;
   logic [BIT_W-1:0]     r_tx_bit,   w_tx_bit_nxt;
   logic [N_BITS-1:0]    r_tx_shift, w_tx_shift_nxt;
   logic                 r_tx,       w_tx_nxt;
   logic                 r_tx_done,  w_tx_done_nxt;

   // Line level is derived from the next state so o_tx is registered
   always_comb begin
      w_tx_state_nxt = r_tx_state;
      w_tx_tick_nxt  = r_tx_tick;
      w_tx_bit_nxt   = r_tx_bit;
      w_tx_shift_nxt = r_tx_shift;
      w_tx_done_nxt  = 1'b0;
      w_tx_nxt       = 1'b1;
      case (r_tx_state)
         UART_IDLE: begin
            if (w_tx_start) begin
               w_tx_state_nxt = UART_START;
               w_tx_tick_nxt  = '0;
               w_tx_shift_nxt = w_alu_result;
            end
         end
         UART_START: begin
            if (w_tick) begin
               if (r_tx_tick == TICK_W'(N_TICKS - 1)) begin
                  w_tx_state_nxt = UART_DATA;
                  w_tx_tick_nxt  = '0;
                  w_tx_bit_nxt   = '0;
               end else begin
                  w_tx_tick_nxt = r_tx_tick + TICK_W'(1);
               end
            end
         end
         UART_DATA: begin
            if (w_tick) begin
               if (r_tx_tick == TICK_W'(N_TICKS - 1)) begin
                  w_tx_tick_nxt  = '0;
                  w_tx_shift_nxt = r_tx_shift >> 1;
                  if (r_tx_bit == BIT_W'(N_BITS - 1)) w_tx_state_nxt = UART_STOP;
                  else                                w_tx_bit_nxt   = r_tx_bit + BIT_W'(1);
               end else begin
                  w_tx_tick_nxt = r_tx_tick + TICK_W'(1);
               end
            end
         end
         UART_STOP: begin
            if (w_tick) begin
               if (r_tx_tick == TICK_W'(N_TICKS - 1)) begin
                  w_tx_state_nxt = UART_IDLE;
                  w_tx_tick_nxt  = '0;
                  w_tx_done_nxt  = 1'b1;
               end else begin
                  w_tx_tick_nxt = r_tx_tick + TICK_W'(1);
               end
            end
         end
         default: w_tx_state_nxt = UART_IDLE;
      endcase

      case (w_tx_state_nxt)
         UART_START: w_tx_nxt = 1'b0;
         UART_DATA:  w_tx_nxt = w_tx_shift_nxt[0];
         default:    w_tx_nxt = 1'b1;
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_tx_state <= UART_IDLE;
         r_tx_tick  <= '0;
         r_tx_bit   <= '0;
         r_tx_shift <= '0;
         r_tx       <= 1'b1;
         r_tx_done  <= 1'b0;
      end else begin
         r_tx_state <= w_tx_state_nxt;
         r_tx_tick  <= w_tx_tick_nxt;
         r_tx_bit   <= w_tx_bit_nxt;
         r_tx_shift <= w_tx_shift_nxt;
         r_tx       <= w_tx_nxt;
         r_tx_done  <= w_tx_done_nxt;
      end
   end

   assign o_tx           = r_tx;
   assign o_tx_done_tick = r_tx_done;

endmodule : uart_alu_top

// File: tb/tb_uart_alu_top.sv
// ---------------------------------------------------------------------------
// tb_uart_alu_top
// Drives A/B/op frames into uart_alu_top, decodes the returned frame and
// compares it against a plain-arithmetic ALU model. The baud divider is
// scaled down (LIMITE=3) so a full transaction takes ~2k clocks.
// ---------------------------------------------------------------------------
module tb_uart_alu_top;

   localparam int unsigned LIMITE   = 3;
   localparam int unsigned NB_CONTA = 2;
   localparam int unsigned N_BITS   = 8;
   localparam int unsigned N_TICKS  = 16;
   localparam int          BIT      = LIMITE * N_TICKS;

   logic clk;
   logic rst;
   logic rx;
   logic tx;
   logic done;

   int n_assert = 0;
   int n_fail   = 0;
   int done_cnt = 0;

   uart_alu_top #(
      .LIMITE   (LIMITE),
      .NB_CONTA (NB_CONTA),
      .N_BITS   (N_BITS),
      .N_TICKS  (N_TICKS)
   ) dut (
      .i_clock        (clk),
      .i_reset        (rst),
      .i_rx           (rx),
      .o_tx_done_tick (done),
      .o_tx           (tx)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

   // Reference: result byte from the operation rules, plain integer math
   function automatic logic [7:0] alu_model(input int a, input int b, input int op);
      int r;
      int sa;
      r = 0;
      case (op % 64)
         32: r = (a + b) % 256;
         34: r = (a - b + 256) % 256;
         36: r = a & b;
         37: r = a | b;
         38: r = a ^ b;
         39: r = 255 - (a | b);
         3: begin
            sa = (a >= 128) ? a - 256 : a;
            if (b >= 8) r = (a >= 128) ? 255 : 0;
            else        r = (sa >>> b) & 255;
         end
         2: r = (b >= 8) ? 0 : a / (1 << b);
         default: r = 0;
      endcase
      return 8'(r);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // kind: 0 full frame, 1 return after the last data bit (line left high),
   //       2 stop bit driven low for a bit over half a bit time
   task automatic send_byte(input logic [7:0] d, input int kind);
      rx = 1'b0;
      repeat (BIT) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         repeat (BIT) @(negedge clk);
      end
      if (kind == 1) begin
         rx = 1'b1;
      end else if (kind == 2) begin
         rx = 1'b0;
         repeat (BIT / 2 + 3 * LIMITE) @(negedge clk);
         rx = 1'b1;
         repeat (2 * BIT) @(negedge clk);
      end else begin
         rx = 1'b1;
         repeat (BIT) @(negedge clk);
      end
   endtask

   task automatic expect_result(input logic [7:0] exp, input string tag);
      int n;
      int d0;
      logic [7:0] got;
      d0 = done_cnt;
      got = '0;
      n = 0;
      while (tx !== 1'b0 && n < 4 * BIT) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_tx_start_seen"}, tx, 0);
      if (tx !== 1'b0) return;
      repeat (BIT / 2) @(negedge clk);
      check({tag, "_start_bit"}, tx, 0);
      for (int i = 0; i < 8; i++) begin
         repeat (BIT) @(negedge clk);
         got[i] = tx;
      end
      check({tag, "_result"}, got, exp);
      repeat (BIT) @(negedge clk);
      check({tag, "_stop_bit"}, tx, 1);
      check({tag, "_no_early_done"}, done_cnt, d0);
      n = 0;
      while (done_cnt == d0 && n < BIT) begin
         @(negedge clk);
         n++;
      end
      repeat (BIT) @(negedge clk);
      check({tag, "_done_once"}, done_cnt, d0 + 1);
   endtask

   task automatic run_triple(input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] op, input string tag);
      send_byte(a, 0);
      send_byte(b, 0);
      send_byte(op, 1);
      expect_result(alu_model(int'(a), int'(b), int'(op)), tag);
   endtask

   initial begin
      logic [7:0] op_tbl [8];
      logic [7:0] ra, rb, rop;
      bit stayed;
      int d0;
      int n;

      op_tbl = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h03, 8'h02};

      // reset values
      rst = 1'b1;
      rx  = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_tx", tx, 1);
      check("reset_done", done, 0);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      check("idle_tx", tx, 1);

      // directed operations
      run_triple(8'h55, 8'h57, 8'h24, "and");
      run_triple(8'h55, 8'h57, 8'h20, "add");
      run_triple(8'h55, 8'h57, 8'h22, "sub");
      run_triple(8'h55, 8'h57, 8'h27, "nor");
      run_triple(8'h55, 8'h57, 8'h26, "xor");
      run_triple(8'h55, 8'h57, 8'h25, "or");
      run_triple(8'h80, 8'h02, 8'h03, "sra");
      run_triple(8'h80, 8'h02, 8'h02, "srl");
      run_triple(8'h80, 8'h09, 8'h02, "srl_b9");
      run_triple(8'h80, 8'h08, 8'h03, "sra_b8");
      run_triple(8'h7F, 8'h09, 8'h03, "sra_pos_b9");
      run_triple(8'h80, 8'h07, 8'h02, "srl_b7");
      run_triple(8'h0F, 8'hF0, 8'hE5, "op_hibits");
      run_triple(8'h55, 8'h57, 8'h01, "inv01");
      run_triple(8'h55, 8'h57, 8'h38, "inv38");
      run_triple(8'h12, 8'h34, 8'h20, "after_inv");

      // randomized triples
      for (int k = 0; k < 6; k++) begin
         ra  = 8'($urandom);
         rb  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 10)) : 8'($urandom);
         rop = ($urandom_range(0, 4) == 0) ? 8'($urandom) : op_tbl[$urandom_range(0, 7)];
         run_triple(ra, rb, rop, $sformatf("rand%0d", k));
      end

      // short low glitch must not start a byte
      rx = 1'b0;
      repeat (6) @(negedge clk);
      rx = 1'b1;
      stayed = 1'b1;
      for (int i = 0; i < 3 * BIT; i++) begin
         @(negedge clk);
         if (tx !== 1'b1) stayed = 1'b0;
      end
      check("glitch_tx_idle", stayed, 1);
      run_triple(8'h55, 8'h57, 8'h20, "post_glitch");

      // reset in the middle of the B frame discards A and the partial byte
      send_byte(8'h11, 0);
      rx = 1'b0;
      repeat (BIT) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         rx = 1'(i % 2);
         repeat (BIT) @(negedge clk);
      end
      rst = 1'b1;
      rx  = 1'b1;
      @(negedge clk);
      check("rst_mid_b_tx", tx, 1);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (2 * BIT) @(negedge clk);
      run_triple(8'h80, 8'h02, 8'h02, "post_reset_b");

      // reset while the result frame is on the line
      send_byte(8'h55, 0);
      send_byte(8'h57, 0);
      send_byte(8'h01, 1);
      n = 0;
      while (tx !== 1'b0 && n < 4 * BIT) begin
         @(negedge clk);
         n++;
      end
      check("rst_mid_tx_start_seen", tx, 0);
      repeat (BIT) @(negedge clk);
      d0 = done_cnt;
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_tx_line_high", tx, 1);
      rst = 1'b0;
      stayed = 1'b1;
      for (int i = 0; i < 12 * BIT; i++) begin
         @(negedge clk);
         if (tx !== 1'b1) stayed = 1'b0;
      end
      check("rst_mid_tx_stays_idle", stayed, 1);
      check("rst_mid_tx_no_done", done_cnt, d0);
      run_triple(8'hC3, 8'h3C, 8'h26, "post_reset_tx");

      // frame with a low stop bit in the B slot
`ifdef UART_FRAME_CHECK_EN
      send_byte(8'h34, 0);
      send_byte(8'hAA, 2);
      send_byte(8'h12, 0);
      send_byte(8'h22, 1);
      expect_result(alu_model(8'h34, 8'h12, 8'h22), "frame_err_dropped");
`else
      send_byte(8'h34, 0);
      send_byte(8'hAA, 2);
      send_byte(8'h22, 1);
      expect_result(alu_model(8'h34, 8'hAA, 8'h22), "bad_stop_accepted");
`endif
      run_triple(8'h01, 8'hFF, 8'h20, "final_add_wrap");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule : tb_uart_alu_top
